pcileech_cfgspace_arbiter: RTL

PCILEECH_CFGSPACE_ARBITER -- requirements
Module: pcileech_cfgspace_arbiter

---
 rtl/pcileech_cfgspace_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pcileech_cfgspace_arbiter.sv
// pcileech_cfgspace_arbiter
// Three-way arbiter in front of the config-space BRAM wrapper.
// Requesters: PCIe cfg TLP, USB shadow access, internal logic.
// Base priority TLP > USB > INT. Losers are held by their source.
// A read of the address written by the previous grant is held off one cycle.
// Optional build macro CFGSPACE_ARB_STARVE_GUARD_EN: once starve_cnt reaches
// STARVE_MAX, USB then INT win over TLP for one grant.
//
// state   | meaning
// IDLE    | no grant last cycle
// GNT_RD  | last cycle granted a read
// GNT_WR  | last cycle granted a write (bram_addr holds its address)
// STALL   | last cycle was a hazard bubble, no grant issued
module pcileech_cfgspace_arbiter #(
  parameter int STARVE_MAX = 15
) (
  input  logic        clk_pcie,
  input  logic        rst,
  input  logic        tlp_valid,
  input  logic        tlp_wr,
  input  logic [9:0]  tlp_addr,
  input  logic [3:0]  tlp_be,
  input  logic [31:0] tlp_data,
  input  logic [7:0]  tlp_tag,
  input  logic [15:0] tlp_reqid,
  output logic        tlp_ready,
  input  logic        usb_valid,
  input  logic        usb_wr,
  input  logic [9:0]  usb_addr,
  input  logic        usb_addr_lo,
  input  logic [3:0]  usb_be,
  input  logic [31:0] usb_data,
  output logic        usb_ready,
  input  logic        int_valid,
  input  logic        int_wr,
  input  logic [9:0]  int_addr,
  input  logic [3:0]  int_be,
  input  logic [31:0] int_data,
  output logic        int_ready,
  output logic [9:0]  bram_addr,
  output logic [3:0]  bram_wr_be,
  output logic [31:0] bram_wr_data,
  output logic [7:0]  bram_tag,
  output logic [15:0] bram_reqid,
  output logic [1:0]  bram_tp,
  output logic        bram_tlpwr,
  output logic [3:0]  starve_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_RD = 2'd1,
    GNT_WR = 2'd2,
    STALL  = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  state_t state, state_nxt;

  logic tlp_hz, usb_hz, int_hz;
  logic tlp_ok, usb_ok, int_ok;
  logic gnt_tlp, gnt_usb, gnt_int;
  logic gnt_any, gnt_is_wr, hz_block;

  logic [9:0]  addr_nxt;
  logic [3:0]  be_nxt;
  logic [31:0] data_nxt;
  logic [7:0]  tag_nxt;
  logic [15:0] reqid_nxt;
  logic [1:0]  tp_nxt;
  logic        tlpwr_nxt;

  // Read-after-write hazard detect, grant selection and next-state.
  // Registered bram_addr doubles as the last write address in GNT_WR.
  always_comb begin
    tlp_hz    = (state == GNT_WR) && !tlp_wr && (tlp_addr == bram_addr);
    usb_hz    = (state == GNT_WR) && !usb_wr && (usb_addr == bram_addr);
    int_hz    = (state == GNT_WR) && !int_wr && (int_addr == bram_addr);
    tlp_ok    = tlp_valid && !tlp_hz;
    usb_ok    = usb_valid && !usb_hz;
    int_ok    = int_valid && !int_hz;
    gnt_tlp   = 1'b0;
    gnt_usb   = 1'b0;
    gnt_int   = 1'b0;
`ifdef CFGSPACE_ARB_STARVE_GUARD_EN
    if (starve_cnt == STARVE_TOP && (usb_ok || int_ok)) begin
      gnt_usb = usb_ok;
      gnt_int = !usb_ok && int_ok;
    end else begin
      gnt_tlp = tlp_ok;
      gnt_usb = !tlp_ok && usb_ok;
      gnt_int = !tlp_ok && !usb_ok && int_ok;
    end
`else
    gnt_tlp = tlp_ok;
    gnt_usb = !tlp_ok && usb_ok;
    gnt_int = !tlp_ok && !usb_ok && int_ok;
`endif
    gnt_any   = gnt_tlp || gnt_usb || gnt_int;
    gnt_is_wr = (gnt_tlp && tlp_wr) || (gnt_usb && usb_wr) || (gnt_int && int_wr);
    hz_block  = (tlp_valid && tlp_hz) || (usb_valid && usb_hz) || (int_valid && int_hz);
    if (gnt_any)
      state_nxt = gnt_is_wr ? GNT_WR : GNT_RD;
    else if (hz_block)
      state_nxt = STALL;
    else
      state_nxt = IDLE;
  end

  // Ready outputs: the grant itself, forced low while reset is asserted.
  always_comb begin
    tlp_ready = gnt_tlp && !rst;
    usb_ready = gnt_usb && !rst;
    int_ready = gnt_int && !rst;
  end

  // BRAM request mux for the winning requester; all zero when idle.
  always_comb begin
    addr_nxt  = '0;
    be_nxt    = '0;
    data_nxt  = '0;
    tag_nxt   = '0;
    reqid_nxt = '0;
    tp_nxt    = 2'b00;
    tlpwr_nxt = 1'b0;
    if (gnt_tlp) begin
      addr_nxt  = tlp_addr;
      be_nxt    = tlp_wr ? tlp_be : 4'h0;
      data_nxt  = tlp_data;
      tag_nxt   = tlp_tag;
      reqid_nxt = tlp_reqid;
      tp_nxt    = 2'b01;
      tlpwr_nxt = tlp_wr;
    end else if (gnt_usb) begin
      addr_nxt  = usb_addr;
      be_nxt    = usb_wr ? usb_be : 4'h0;
      data_nxt  = usb_data;
      tag_nxt   = {7'h0, usb_addr_lo};
      tp_nxt    = usb_wr ? 2'b00 : 2'b10;
    end else if (gnt_int) begin
      addr_nxt  = int_addr;
      be_nxt    = int_wr ? int_be : 4'h0;
      data_nxt  = int_data;
    end
  end

  // State register.
  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered BRAM request, valid for exactly the cycle after the grant.
  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst) begin
      bram_addr    <= '0;
      bram_wr_be   <= '0;
      bram_wr_data <= '0;
      bram_tag     <= '0;
      bram_reqid   <= '0;
      bram_tp      <= 2'b00;
      bram_tlpwr   <= 1'b0;
    end else begin
      bram_addr    <= addr_nxt;
      bram_wr_be   <= be_nxt;
      bram_wr_data <= data_nxt;
      bram_tag     <= tag_nxt;
      bram_reqid   <= reqid_nxt;
      bram_tp      <= tp_nxt;
      bram_tlpwr   <= tlpwr_nxt;
    end
  end

  // Consecutive TLP grants while another requester is waiting, saturating.
  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (gnt_usb || gnt_int || !(usb_valid || int_valid))
      starve_cnt <= '0;
    else if (gnt_tlp && starve_cnt != STARVE_TOP)
      starve_cnt <= starve_cnt + 4'd1;
  end

endmodule
